// File: rtl/backward_controller.sv
// Backpropagation sequencer: latches the output-layer error, then walks one shared propagation layer downward.
// Optional WAIT watchdog is compiled in with `define BACKWARD_TIMEOUT_EN.
module backward_controller #(
    parameter int                     LAYER_MAX       = 3,
    parameter int                     NUM_NEURON      = 5,
    parameter int                     DELTA_SIZE      = 9,
    parameter int                     LAYER_ADDR_SIZE = 2,
    parameter logic [4*LAYER_MAX-1:0] LAYER_SIZES     = {LAYER_MAX{4'd5}},
    parameter int                     TIMEOUT_CYCLES  = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_NEURON*DELTA_SIZE-1:0] output_error,
    input  logic [NUM_NEURON*DELTA_SIZE-1:0] layer_delta,
    input  logic [NUM_NEURON-1:0]            layer_delta_valid,
    output logic                             layer_start,
    output logic [LAYER_ADDR_SIZE-1:0]       layer_num,
    output logic [NUM_NEURON-1:0]            active,
    output logic [NUM_NEURON*DELTA_SIZE-1:0] layer_error,
    output logic [NUM_NEURON*DELTA_SIZE-1:0] delta_out,
    output logic                             delta_out_valid,
    output logic [LAYER_ADDR_SIZE-1:0]       delta_layer,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout
);

    localparam int VEC_W = NUM_NEURON * DELTA_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_STORE,
        ST_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [LAYER_ADDR_SIZE-1:0] layer_num_q, layer_num_d;
    logic [LAYER_ADDR_SIZE-1:0] delta_layer_q, delta_layer_d;
    logic [VEC_W-1:0]           err_q, err_d;
    logic [VEC_W-1:0]           dreg_q, dreg_d;
    logic [VEC_W-1:0]           delta_out_q, delta_out_d;
    logic [NUM_NEURON-1:0]      seen_q, seen_d;

    logic [3:0]                 lane_count;
    logic [NUM_NEURON-1:0]      active_mask;
    logic [VEC_W-1:0]           lane_mask;
    logic [NUM_NEURON-1:0]      hit;
    logic [NUM_NEURON-1:0]      seen_next;
    logic [VEC_W-1:0]           dreg_merge;

`ifdef BACKWARD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // Lane mask of the layer being stepped; layer index 0 means no step configured yet.
    always_comb begin
        lane_count  = 4'd0;
        active_mask = '0;
        lane_mask   = '0;
        if (layer_num_q != '0) begin
            lane_count = LAYER_SIZES[4*(int'(layer_num_q)-1) +: 4];
        end
        for (int i = 0; i < NUM_NEURON; i++) begin
            if (i < int'(lane_count)) begin
                active_mask[i]                        = 1'b1;
                lane_mask[i*DELTA_SIZE +: DELTA_SIZE] = '1;
            end
        end
    end

    always_comb begin
        hit        = layer_delta_valid & active_mask;
        seen_next  = seen_q | hit;
        dreg_merge = dreg_q;
        for (int i = 0; i < NUM_NEURON; i++) begin
            if (hit[i]) begin
                dreg_merge[i*DELTA_SIZE +: DELTA_SIZE] = layer_delta[i*DELTA_SIZE +: DELTA_SIZE];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        layer_num_d   = layer_num_q;
        delta_layer_d = delta_layer_q;
        err_d         = err_q;
        dreg_d        = dreg_q;
        delta_out_d   = delta_out_q;
        seen_d        = seen_q;
`ifdef BACKWARD_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_d     = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d       = output_error;
                    seen_d      = '0;
                    layer_num_d = LAYER_ADDR_SIZE'(LAYER_MAX - 1);
`ifdef BACKWARD_TIMEOUT_EN
                    timeout_d   = 1'b0;
`endif
                    state_d     = (LAYER_MAX == 1) ? ST_DONE : ST_START;
                end
            end
            ST_START: begin
`ifdef BACKWARD_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                dreg_d = dreg_merge;
                seen_d = seen_next;
                // Completion in the same cycle as the last valid lane takes priority over the watchdog.
                if (seen_next == active_mask) begin
                    delta_out_d   = dreg_merge & lane_mask;
                    delta_layer_d = layer_num_q - LAYER_ADDR_SIZE'(1);
                    state_d       = ST_STORE;
                end
`ifdef BACKWARD_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    seen_d    = '0;
                    state_d   = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_STORE: begin
                err_d  = delta_out_q;
                seen_d = '0;
                if (layer_num_q == LAYER_ADDR_SIZE'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    layer_num_d = layer_num_q - LAYER_ADDR_SIZE'(1);
                    state_d     = ST_START;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            layer_num_q   <= '0;
            delta_layer_q <= '0;
            err_q         <= '0;
            dreg_q        <= '0;
            delta_out_q   <= '0;
            seen_q        <= '0;
`ifdef BACKWARD_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            layer_num_q   <= layer_num_d;
            delta_layer_q <= delta_layer_d;
            err_q         <= err_d;
            dreg_q        <= dreg_d;
            delta_out_q   <= delta_out_d;
            seen_q        <= seen_d;
`ifdef BACKWARD_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign layer_start     = (state_q == ST_START);
    assign delta_out_valid = (state_q == ST_STORE);
    assign done            = (state_q == ST_DONE);
    assign busy            = (state_q != ST_IDLE);
    assign layer_num       = layer_num_q;
    assign active          = active_mask;
    assign layer_error     = err_q;
    assign delta_out       = delta_out_q;
    assign delta_layer     = delta_layer_q;
`ifdef BACKWARD_TIMEOUT_EN
    assign timeout         = timeout_q;
`else
    assign timeout         = 1'b0;
`endif

endmodule

// File: tb/tb_backward_controller.sv
// Self-checking bench for backward_controller: event-level reference model compared every cycle,
// plus directed passes with hand-computed expectations. Layer 0 is sized to 3 lanes, layer 1 to 5.
`timescale 1ns/1ps
module tb_backward_controller;

    localparam int              LAYER_MAX = 3;
    localparam int              NN        = 5;
    localparam int              DS        = 9;
    localparam int              AW        = 2;
    localparam int              VW        = NN * DS;
    localparam logic [11:0]     SIZES     = {4'd5, 4'd5, 4'd3};
    localparam int              TO_CYCLES = 16;
`ifdef BACKWARD_TIMEOUT_EN
    localparam bit              TIMEOUT_ON = 1'b1;
`else
    localparam bit              TIMEOUT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [VW-1:0] output_error;
    logic [VW-1:0] layer_delta;
    logic [NN-1:0] layer_delta_valid;
    logic          layer_start;
    logic [AW-1:0] layer_num;
    logic [NN-1:0] active;
    logic [VW-1:0] layer_error;
    logic [VW-1:0] delta_out;
    logic          delta_out_valid;
    logic [AW-1:0] delta_layer;
    logic          busy;
    logic          done;
    logic          timeout;

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;
    bit checking   = 1'b0;

    int launch_count;
    int done_count;
    int dl_log[$];

    backward_controller #(
        .LAYER_MAX(LAYER_MAX), .NUM_NEURON(NN), .DELTA_SIZE(DS), .LAYER_ADDR_SIZE(AW),
        .LAYER_SIZES(SIZES), .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .output_error(output_error),
        .layer_delta(layer_delta), .layer_delta_valid(layer_delta_valid),
        .layer_start(layer_start), .layer_num(layer_num), .active(active),
        .layer_error(layer_error), .delta_out(delta_out), .delta_out_valid(delta_out_valid),
        .delta_layer(delta_layer), .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("[TB] FAIL global_time_limit: cycle %0d reached, required finish earlier", cyc);
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got 'h%0h, required 'h%0h", name, cyc, actual, expected);
        end
    endtask

    function automatic logic [VW-1:0] lanes5(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c,
                                             input logic [8:0] d, input logic [8:0] e);
        return {e, d, c, b, a};
    endfunction

    function automatic int maskOf(input int layer);
        int n;
        if (layer < 1) return 0;
        n = int'(SIZES[4*(layer-1) +: 4]);
        return (1 << n) - 1;
    endfunction

    // Reference model: tracks the pass as a chain of events (launch, collect, report, finish).
    int m_err [NN];
    int m_val [NN];
    int m_rep [NN];
    bit m_got [NN];
    bit m_collect;
    int m_waited;
    bit e_layer_start, e_delta_valid, e_busy, e_done, e_timeout;
    int e_layer_num, e_delta_layer;

    always @(posedge clk) begin : model
        bit was_busy, was_launch, was_report, was_done, all_in;
        int mask;
        if (rst) begin
            for (int i = 0; i < NN; i++) begin
                m_err[i] = 0; m_val[i] = 0; m_rep[i] = 0; m_got[i] = 1'b0;
            end
            m_collect = 1'b0; m_waited = 0;
            e_layer_start = 1'b0; e_delta_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_timeout = 1'b0;
            e_layer_num = 0; e_delta_layer = 0;
        end else begin
            was_busy   = e_busy;
            was_launch = e_layer_start;
            was_report = e_delta_valid;
            was_done   = e_done;
            e_layer_start = 1'b0;
            e_delta_valid = 1'b0;
            e_done        = 1'b0;
            if (was_done) e_busy = 1'b0;
            if (!was_busy && start) begin
                for (int i = 0; i < NN; i++) m_err[i] = int'(output_error[i*DS +: DS]);
                e_layer_num = LAYER_MAX - 1;
                e_busy      = 1'b1;
                e_timeout   = 1'b0;
                if (LAYER_MAX == 1) e_done = 1'b1;
                else                e_layer_start = 1'b1;
            end else if (was_launch) begin
                m_collect = 1'b1;
                m_waited  = 0;
                for (int i = 0; i < NN; i++) m_got[i] = 1'b0;
            end else if (m_collect) begin
                mask   = maskOf(e_layer_num);
                all_in = 1'b1;
                for (int i = 0; i < NN; i++) begin
                    if (mask[i]) begin
                        if (layer_delta_valid[i]) begin
                            m_got[i] = 1'b1;
                            m_val[i] = int'(layer_delta[i*DS +: DS]);
                        end
                        if (!m_got[i]) all_in = 1'b0;
                    end
                end
                if (all_in) begin
                    m_collect     = 1'b0;
                    e_delta_valid = 1'b1;
                    e_delta_layer = e_layer_num - 1;
                    for (int i = 0; i < NN; i++) m_rep[i] = mask[i] ? m_val[i] : 0;
                end else begin
                    m_waited++;
                    if (TIMEOUT_ON && m_waited == TO_CYCLES) begin
                        m_collect = 1'b0;
                        e_busy    = 1'b0;
                        e_timeout = 1'b1;
                    end
                end
            end else if (was_report) begin
                for (int i = 0; i < NN; i++) m_err[i] = m_rep[i];
                if (e_layer_num == 1) e_done = 1'b1;
                else begin
                    e_layer_num   = e_layer_num - 1;
                    e_layer_start = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [VW-1:0] exp_err, exp_dout;
        if (checking) begin
            exp_err  = '0;
            exp_dout = '0;
            for (int i = 0; i < NN; i++) begin
                exp_err[i*DS +: DS]  = DS'(m_err[i]);
                exp_dout[i*DS +: DS] = DS'(m_rep[i]);
            end
            checkOutput("layer_start",     64'(layer_start),     64'(e_layer_start));
            checkOutput("layer_num",       64'(layer_num),       64'(e_layer_num));
            checkOutput("active",          64'(active),          64'(maskOf(e_layer_num)));
            checkOutput("layer_error",     64'(layer_error),     64'(exp_err));
            checkOutput("delta_out",       64'(delta_out),       64'(exp_dout));
            checkOutput("delta_out_valid", 64'(delta_out_valid), 64'(e_delta_valid));
            checkOutput("delta_layer",     64'(delta_layer),     64'(e_delta_layer));
            checkOutput("busy",            64'(busy),            64'(e_busy));
            checkOutput("done",            64'(done),            64'(e_done));
            checkOutput("timeout",         64'(timeout),         64'(e_timeout));
            if (layer_start)     launch_count++;
            if (done)            done_count++;
            if (delta_out_valid) dl_log.push_back(int'(delta_layer));
        end
    end

    task automatic applyStimulus(input logic s, input logic [VW-1:0] oe, input logic [NN-1:0] v,
                                 input logic [VW-1:0] d);
        start             = s;
        output_error      = oe;
        layer_delta_valid = v;
        layer_delta       = d;
        @(posedge clk);
        #1;
        start             = 1'b0;
        layer_delta_valid = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, '0, '0, '0);
    endtask

    task automatic clearLogs();
        launch_count = 0;
        done_count   = 0;
        dl_log.delete();
    endtask

    task automatic waitLaunch(output int lc);
        lc = -1;
        for (int k = 0; k < 40; k++) begin
            if (layer_start) begin
                lc = cyc;
                break;
            end
            idle(1);
        end
        checkOutput("launch_seen", 64'(layer_start), 64'd1);
    endtask

    task automatic waitIdle();
        for (int k = 0; k < 60; k++) begin
            if (!busy) break;
            idle(1);
        end
        checkOutput("pass_finished", 64'(busy), 64'd0);
    endtask

    // Called in a launch cycle; returns in the report cycle.
    task automatic echoStep(input logic [VW-1:0] d);
        idle(3);
        applyStimulus(1'b0, '0, 5'h1F, d);
    endtask

    function automatic int logAt(input int idx);
        return (dl_log.size() > idx) ? dl_log[idx] : -1;
    endfunction

    int t0, l1, l2;

    initial begin
        rst = 1'b1; start = 1'b0; output_error = '0; layer_delta = '0; layer_delta_valid = '0;
        clearLogs();
        @(posedge clk);
        #1;
        checking = 1'b1;
        idle(2);
        checkOutput("reset_busy",      64'(busy),      64'd0);
        checkOutput("reset_layer_num", 64'(layer_num), 64'd0);
        checkOutput("reset_delta_out", 64'(delta_out), 64'd0);
        rst = 1'b0;
        idle(2);

        $display("[TB] test 1: two-step pass, echo 3 cycles after launch");
        clearLogs();
        t0 = cyc;
        applyStimulus(1'b1, lanes5(9'd1, 9'd2, 9'd3, 9'd4, 9'd5), '0, '0);
        waitLaunch(l1);
        checkOutput("t1_first_launch_offset", 64'(l1 - t0), 64'd1);
        checkOutput("t1_layer_num_step1",     64'(layer_num), 64'd2);
        checkOutput("t1_layer_error_step1",   64'(layer_error), 64'(lanes5(9'd1, 9'd2, 9'd3, 9'd4, 9'd5)));
        echoStep(lanes5(9'h010, 9'h011, 9'h012, 9'h013, 9'h014));
        waitLaunch(l2);
        checkOutput("t1_second_launch_offset", 64'(l2 - t0), 64'd6);
        checkOutput("t1_layer_num_step2",      64'(layer_num), 64'd1);
        checkOutput("t1_layer_error_step2",    64'(layer_error),
                    64'(lanes5(9'h010, 9'h011, 9'h012, 9'h013, 9'h014)));
        echoStep(lanes5(9'h020, 9'h021, 9'h022, 9'h023, 9'h024));
        checkOutput("t1_delta_out_step2", 64'(delta_out), 64'(lanes5(9'h020, 9'h021, 9'h022, 9'h000, 9'h000)));
        waitIdle();
        checkOutput("t1_done_count",   64'(done_count),    64'd1);
        checkOutput("t1_report_count", 64'(dl_log.size()), 64'd2);
        checkOutput("t1_delta_layer0", 64'(logAt(0)),      64'd1);
        checkOutput("t1_delta_layer1", 64'(logAt(1)),      64'd0);

        $display("[TB] test 2: 3-lane lower layer masks lanes 3 and 4");
        clearLogs();
        applyStimulus(1'b1, lanes5(9'h1F0, 9'h00F, 9'h100, 9'h0FF, 9'h001), '0, '0);
        waitLaunch(l1);
        checkOutput("t2_active_step1", 64'(active), 64'h1F);
        echoStep(lanes5(9'h101, 9'h102, 9'h103, 9'h104, 9'h105));
        waitLaunch(l2);
        checkOutput("t2_active_step2", 64'(active), 64'h07);
        echoStep(lanes5(9'h100, 9'h0AA, 9'h055, 9'h1FF, 9'h1FF));
        checkOutput("t2_report_valid",  64'(delta_out_valid), 64'd1);
        checkOutput("t2_delta_out",     64'(delta_out), 64'(lanes5(9'h100, 9'h0AA, 9'h055, 9'h000, 9'h000)));
        waitIdle();

        $display("[TB] test 3: staggered lane valids with one overwrite");
        clearLogs();
        applyStimulus(1'b1, lanes5(9'd7, 9'd7, 9'd7, 9'd7, 9'd7), '0, '0);
        waitLaunch(l1);
        idle(1);
        applyStimulus(1'b0, '0, 5'b00001, lanes5(9'h011, 9'h0, 9'h0, 9'h0, 9'h0));
        applyStimulus(1'b0, '0, 5'b00010, lanes5(9'h0, 9'h022, 9'h0, 9'h0, 9'h0));
        applyStimulus(1'b0, '0, 5'b00101, lanes5(9'h1EE, 9'h0, 9'h033, 9'h0, 9'h0));
        applyStimulus(1'b0, '0, 5'b01000, lanes5(9'h0, 9'h0, 9'h0, 9'h044, 9'h0));
        checkOutput("t3_no_early_report", 64'(delta_out_valid), 64'd0);
        applyStimulus(1'b0, '0, 5'b10000, lanes5(9'h0, 9'h0, 9'h0, 9'h0, 9'h055));
        checkOutput("t3_report_valid",  64'(delta_out_valid), 64'd1);
        checkOutput("t3_report_offset", 64'(cyc - l1), 64'd6);
        checkOutput("t3_delta_out",     64'(delta_out), 64'(lanes5(9'h1EE, 9'h022, 9'h033, 9'h044, 9'h055)));
        waitLaunch(l2);
        echoStep(lanes5(9'h001, 9'h002, 9'h003, 9'h004, 9'h005));
        waitIdle();
        checkOutput("t3_report_count", 64'(dl_log.size()), 64'd2);

        $display("[TB] test 4: start while busy and in the done cycle");
        clearLogs();
        applyStimulus(1'b1, lanes5(9'd9, 9'd8, 9'd7, 9'd6, 9'd5), '0, '0);
        waitLaunch(l1);
        idle(1);
        applyStimulus(1'b1, lanes5(9'h1AA, 9'h1AA, 9'h1AA, 9'h1AA, 9'h1AA), '0, '0);
        idle(1);
        applyStimulus(1'b0, '0, 5'h1F, lanes5(9'h031, 9'h032, 9'h033, 9'h034, 9'h035));
        waitLaunch(l2);
        echoStep(lanes5(9'h041, 9'h042, 9'h043, 9'h044, 9'h045));
        for (int k = 0; k < 10; k++) begin
            if (done) break;
            idle(1);
        end
        checkOutput("t4_done_seen", 64'(done), 64'd1);
        applyStimulus(1'b1, lanes5(9'h1BB, 9'h1BB, 9'h1BB, 9'h1BB, 9'h1BB), '0, '0);
        checkOutput("t4_busy_after_done", 64'(busy), 64'd0);
        idle(3);
        checkOutput("t4_still_idle",    64'(busy),         64'd0);
        checkOutput("t4_done_count",    64'(done_count),   64'd1);
        checkOutput("t4_launch_count",  64'(launch_count), 64'd2);

        $display("[TB] test 5: reset in the middle of step 1");
        clearLogs();
        applyStimulus(1'b1, lanes5(9'd3, 9'd3, 9'd3, 9'd3, 9'd3), '0, '0);
        waitLaunch(l1);
        idle(1);
        rst = 1'b1;
        applyStimulus(1'b0, '0, 5'h1F, lanes5(9'h0EE, 9'h0EE, 9'h0EE, 9'h0EE, 9'h0EE));
        rst = 1'b0;
        checkOutput("t5_busy_cleared",      64'(busy),        64'd0);
        checkOutput("t5_no_launch",         64'(layer_start), 64'd0);
        checkOutput("t5_delta_out_cleared", 64'(delta_out),   64'd0);
        idle(4);
        checkOutput("t5_no_done", 64'(done_count), 64'd0);
        t0 = cyc;
        applyStimulus(1'b1, lanes5(9'd4, 9'd4, 9'd4, 9'd4, 9'd4), '0, '0);
        waitLaunch(l1);
        checkOutput("t5_fresh_launch_offset", 64'(l1 - t0), 64'd1);
        echoStep(lanes5(9'h061, 9'h062, 9'h063, 9'h064, 9'h065));
        waitLaunch(l2);
        echoStep(lanes5(9'h071, 9'h072, 9'h073, 9'h074, 9'h075));
        waitIdle();
        checkOutput("t5_done_count",   64'(done_count),    64'd1);
        checkOutput("t5_report_count", 64'(dl_log.size()), 64'd2);

`ifdef BACKWARD_TIMEOUT_EN
        $display("[TB] test 6: watchdog abort with no valids");
        clearLogs();
        applyStimulus(1'b1, lanes5(9'd2, 9'd2, 9'd2, 9'd2, 9'd2), '0, '0);
        waitLaunch(l1);
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            idle(1);
        end
        checkOutput("t6_abort_offset", 64'(cyc - l1),      64'd17);
        checkOutput("t6_timeout_flag", 64'(timeout),       64'd1);
        checkOutput("t6_no_done",      64'(done_count),    64'd0);
        checkOutput("t6_no_report",    64'(dl_log.size()), 64'd0);
        idle(2);
        checkOutput("t6_timeout_sticky", 64'(timeout), 64'd1);
        applyStimulus(1'b1, lanes5(9'd6, 9'd6, 9'd6, 9'd6, 9'd6), '0, '0);
        checkOutput("t6_timeout_cleared", 64'(timeout), 64'd0);
        waitLaunch(l1);
        echoStep(lanes5(9'h081, 9'h082, 9'h083, 9'h084, 9'h085));
        waitLaunch(l2);
        echoStep(lanes5(9'h091, 9'h092, 9'h093, 9'h094, 9'h095));
        waitIdle();
        checkOutput("t6_done_after_recovery", 64'(done_count), 64'd1);
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
